// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI-style SRAM slave, 2^MEM_AW x 32-bit words, independent read and write engines.
// Latency: first R beat one cycle after the AR handshake. W data lands on each W handshake. B follows the wlast beat by one cycle.
// Backpressure: one burst is outstanding per engine. Outputs hold while rready/bready are low.
//   With AXI_SRAM_SLAVE_STALL_EN defined, an LFSR also withholds ready signals and R launches.
// Ports: clk, reset (sync, active-high).
//   AR: arid/araddr/arlen/arburst/arvalid -> arready.
//   R:  rid/rdata/rresp/rlast/rvalid <- rready.
//   AW: awid/awaddr/awlen/awburst/awvalid -> awready.
//   W:  wdata/wstrb/wlast/wvalid -> wready.
//   B:  bid/bresp/bvalid <- bready.
module axi_sram_slave #(
    parameter int MEM_AW = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);
    localparam int         DEPTH       = 1 << MEM_AW;
    localparam logic [1:0] BURST_FIXED = 2'b00;

    typedef logic [MEM_AW-1:0] widx_t;
    typedef enum logic {R_IDLE, R_BEAT} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    // WRAP is handled exactly like INCR. The word index wraps naturally at 2^MEM_AW.
    function automatic widx_t next_idx(input widx_t idx, input logic [1:0] burst);
        return (burst == BURST_FIXED) ? idx : idx + widx_t'(1);
    endfunction

    logic [31:0] mem [DEPTH];

    // go: permission for ready assertion and R launch this cycle.
    logic go;
`ifdef AXI_SRAM_SLAVE_STALL_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk) begin
        if (reset) lfsr <= 16'hACE1;
        else       lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
    assign go = lfsr[0];
`else
    assign go = 1'b1;
`endif

    // Byte-offset bits, bits above the word index and awlen play no part in addressing.
    // wlast alone terminates a write burst.
    logic unused_bits;
    assign unused_bits = ^{awlen, araddr[31:MEM_AW+2], araddr[1:0],
                           awaddr[31:MEM_AW+2], awaddr[1:0]};

    assign rresp = 2'b00;
    assign bresp = 2'b00;

    // ---------------- read engine ----------------
    r_state_t   r_state, r_state_nxt;
    widx_t      r_addr;       // word index of the next beat to load
    widx_t      r_load_addr;
    logic [7:0] r_left;       // beats still to be loaded after the one on the bus
    logic [1:0] r_burst;
    logic       ar_hs, r_hs, r_load;

    always_comb begin
        arready     = (r_state == R_IDLE) && go;
        ar_hs       = arvalid && arready;
        r_hs        = rvalid && rready;
        r_state_nxt = r_state;
        r_load      = 1'b0;
        r_load_addr = r_addr;
        case (r_state)
            R_IDLE: begin
                if (ar_hs) begin
                    r_state_nxt = R_BEAT;
                    r_load      = 1'b1;
                    r_load_addr = araddr[MEM_AW+1:2];
                end
            end
            R_BEAT: begin
                if (r_hs && rlast) begin
                    r_state_nxt = R_IDLE;
                end else if ((r_hs || !rvalid) && go) begin
                    // Refill in the same edge as the handshake, or launch a beat
                    // that was held off by a stall.
                    r_load = 1'b1;
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= R_IDLE;
        else       r_state <= r_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rid     <= 4'h0;
            rdata   <= 32'h0;
            r_addr  <= '0;
            r_left  <= 8'h0;
            r_burst <= 2'b00;
        end else begin
            if (ar_hs) begin
                rid     <= arid;
                r_burst <= arburst;
            end
            if (r_load) begin
                // A write to the same word on this edge is not yet visible here.
                rdata  <= mem[r_load_addr];
                rvalid <= 1'b1;
                if (ar_hs) begin
                    r_left <= arlen;
                    rlast  <= (arlen == 8'd0);
                    r_addr <= next_idx(r_load_addr, arburst);
                end else begin
                    r_left <= r_left - 8'd1;
                    rlast  <= (r_left == 8'd1);
                    r_addr <= next_idx(r_addr, r_burst);
                end
            end else if (r_hs) begin
                rvalid <= 1'b0;
                rlast  <= 1'b0;
            end
        end
    end

    // ---------------- write engine ----------------
    w_state_t   w_state, w_state_nxt;
    widx_t      w_addr;
    logic [1:0] w_burst;
    logic       aw_hs, w_hs;

    always_comb begin
        awready     = (w_state == W_IDLE) && go;
        wready      = (w_state == W_DATA) && go;
        bvalid      = (w_state == W_RESP);
        aw_hs       = awvalid && awready;
        w_hs        = wvalid && wready;
        w_state_nxt = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs)          w_state_nxt = W_DATA;
            W_DATA:  if (w_hs && wlast)  w_state_nxt = W_RESP;
            W_RESP:  if (bready)         w_state_nxt = W_IDLE;
            default:                     w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) w_state <= W_IDLE;
        else       w_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bid     <= 4'h0;
            w_addr  <= '0;
            w_burst <= 2'b00;
        end else if (aw_hs) begin
            bid     <= awid;
            w_addr  <= awaddr[MEM_AW+1:2];
            w_burst <= awburst;
        end else if (w_hs) begin
            w_addr  <= next_idx(w_addr, w_burst);
        end
    end

    // Memory contents survive reset. A beat in flight at reset is dropped.
    always_ff @(posedge clk) begin
        if (w_hs && !reset) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[w_addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
module tb_axi_sram_slave;
    localparam int MEM_AW = 10;
    localparam int WORDS  = 1 << MEM_AW;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [1:0]  arburst;
    logic        arvalid, arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast, rvalid, rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [1:0]  awburst;
    logic        awvalid, awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid, wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid, bready;

    axi_sram_slave #(.MEM_AW(MEM_AW)) dut (
        .clk(clk), .reset(reset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference memory: word-addressed, with a flag for words whose full contents are known.
    logic [31:0] ref_mem   [WORDS];
    bit          ref_known [WORDS];
    logic [31:0] wr_q [$];
    logic [31:0] rd_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    function automatic int word_of(input logic [31:0] addr);
        return int'(addr[31:2]) % WORDS;
    endfunction

    function automatic int step_word(input int idx, input logic [1:0] burst);
        return (burst == 2'b00) ? idx : (idx + 1) % WORDS;
    endfunction

    function automatic void model_write(input int idx, input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[8*b +: 8] = strb[b] ? 8'hFF : 8'h00;
        ref_mem[idx] = (ref_mem[idx] & ~m) | (data & m);
        if (strb == 4'hF) ref_known[idx] = 1'b1;
    endfunction

    // Write burst with the beats in wr_q. wlast marks the final queue entry, whatever len says.
    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [1:0] burst,
                            input logic [7:0] len, input logic [3:0] strb);
        int   cyc;
        int   idx;
        logic early_b;
        idx = word_of(addr);
        awid = id; awaddr = addr; awburst = burst; awlen = len; awvalid = 1'b1;
        cyc = 0;
        while (!awready && cyc < 200) begin tick(); cyc++; end
        chk1("aw_accept", awready, 1'b1);
        tick();
        awvalid = 1'b0;
        early_b = 1'b0;
        for (int i = 0; i < wr_q.size(); i++) begin
            wvalid = 1'b1; wdata = wr_q[i]; wstrb = strb; wlast = (i == wr_q.size() - 1);
            cyc = 0;
            while (!wready && cyc < 200) begin
                if (bvalid) early_b = 1'b1;
                tick(); cyc++;
            end
            if (bvalid) early_b = 1'b1;
            if (!wready) begin
                chk1("w_accept", wready, 1'b1);
                break;
            end
            model_write(idx, wr_q[i], strb);
            idx = step_word(idx, burst);
            tick();
        end
        wvalid = 1'b0; wlast = 1'b0;
        chk1("b_not_before_wlast", early_b, 1'b0);
        bready = 1'b1;
        cyc = 0;
        while (!bvalid && cyc < 200) begin tick(); cyc++; end
        chk1("b_valid", bvalid, 1'b1);
        chk32("bid", 32'(bid), 32'(id));
        chk32("bresp", 32'(bresp), 32'd0);
        tick();
        bready = 1'b0;
        chk1("b_single", bvalid, 1'b0);
    endtask

    // Read burst. mode 0: rready high; 1: rready toggles each cycle; 2: random rready.
    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [1:0] burst,
                           input logic [7:0] len, input int mode);
        int          cyc, beats, idx;
        logic        held, stab_ok, last_ok, tag_ok, hl;
        logic [31:0] hd;
        idx = word_of(addr);
        rd_q.delete();
        arid = id; araddr = addr; arburst = burst; arlen = len; arvalid = 1'b1;
        cyc = 0;
        while (!arready && cyc < 200) begin tick(); cyc++; end
        chk1("ar_accept", arready, 1'b1);
        tick();
        arvalid = 1'b0;
`ifndef AXI_SRAM_SLAVE_STALL_EN
        chk1("r_first_beat_latency", rvalid, 1'b1);
`endif
        beats = 0; cyc = 0; held = 1'b0; hd = 32'h0; hl = 1'b0;
        stab_ok = 1'b1; last_ok = 1'b1; tag_ok = 1'b1;
        while (beats <= int'(len) && cyc < 2000) begin
            case (mode)
                0:       rready = 1'b1;
                1:       rready = cyc[0];
                default: rready = 1'($urandom_range(0, 1));
            endcase
            if (held && (!rvalid || rdata !== hd || rlast !== hl)) stab_ok = 1'b0;
            held = 1'b0;
            if (rvalid) begin
                if (rready) begin
                    rd_q.push_back(rdata);
                    if (rlast !== (beats == int'(len))) last_ok = 1'b0;
                    if (rid !== id || rresp !== 2'b00) tag_ok = 1'b0;
                    if (ref_known[idx]) chk32("rdata_vs_model", rdata, ref_mem[idx]);
                    idx = step_word(idx, burst);
                    beats++;
                end else begin
                    held = 1'b1; hd = rdata; hl = rlast;
                end
            end
            tick();
            cyc++;
        end
        rready = 1'b0;
        chk32("r_beat_count", 32'(beats), 32'(len) + 32'd1);
        chk1("r_stable_while_stalled", stab_ok, 1'b1);
        chk1("r_rlast_position", last_ok, 1'b1);
        chk1("r_rid_rresp", tag_ok, 1'b1);
    endtask

    typedef struct {
        logic [31:0] wr_addr;
        logic [31:0] rd_addr;
        logic [31:0] pre;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [3:0]  id;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [6];
    int   cyc;

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Single-beat write over a preset word, then read back. Strobes, aliasing and
        // ignored byte-offset bits are all exercised here.
        vecs[0] = '{32'h0000_0040, 32'h0000_0040, 32'h0000_0000, 32'h1234_5678, 4'hF,    4'h1, 32'h1234_5678};
        vecs[1] = '{32'h0000_0080, 32'h0000_0080, 32'h0000_0000, 32'hFFFF_FFFF, 4'b0010, 4'h3, 32'h0000_FF00};
        vecs[2] = '{32'h0000_0084, 32'h0000_0084, 32'hA5A5_A5A5, 32'h0000_0000, 4'b1001, 4'h7, 32'h00A5_A500};
        vecs[3] = '{32'h0000_1000, 32'h0000_0000, 32'h0000_0000, 32'hCAFE_BABE, 4'hF,    4'hA, 32'hCAFE_BABE};
        vecs[4] = '{32'h0000_00C3, 32'h0000_00C0, 32'h1111_1111, 32'h2222_3333, 4'b1100, 4'hF, 32'h2222_1111};
        vecs[5] = '{32'hFFFF_FFFC, 32'h0000_0FFE, 32'h0000_0000, 32'h89AB_CDEF, 4'hF,    4'h5, 32'h89AB_CDEF};

        reset = 1'b1;
        arid = 4'h0; araddr = 32'h0; arlen = 8'h0; arburst = 2'b01; arvalid = 1'b0; rready = 1'b0;
        awid = 4'h0; awaddr = 32'h0; awlen = 8'h0; awburst = 2'b01; awvalid = 1'b0;
        wdata = 32'h0; wstrb = 4'h0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset state
`ifndef AXI_SRAM_SLAVE_STALL_EN
        chk1("rst_arready", arready, 1'b1);
        chk1("rst_awready", awready, 1'b1);
`endif
        chk1("rst_wready", wready, 1'b0);
        chk1("rst_rvalid", rvalid, 1'b0);
        chk1("rst_bvalid", bvalid, 1'b0);
        chk1("rst_rlast", rlast, 1'b0);
        chk32("rst_rid", 32'(rid), 32'd0);
        chk32("rst_bid", 32'(bid), 32'd0);
        chk32("rst_rdata", rdata, 32'd0);
        chk32("rst_resp", 32'({rresp, bresp}), 32'd0);

        // Table-driven single-beat cases
        for (int i = 0; i < 6; i++) begin
            wr_q = '{vecs[i].pre};
            do_write(vecs[i].id, vecs[i].wr_addr, 2'b01, 8'd0, 4'hF);
            wr_q = '{vecs[i].data};
            do_write(vecs[i].id, vecs[i].wr_addr, 2'b01, 8'd0, vecs[i].strb);
            do_read(vecs[i].id, vecs[i].rd_addr, 2'b01, 8'd0, 0);
            chk32($sformatf("vec%0d_rdata", i), (rd_q.size() > 0) ? rd_q[0] : 32'hxxxx_xxxx, vecs[i].exp);
        end

        // INCR read, arlen 3, rready toggling
        wr_q = '{32'hA000_0100, 32'hA000_0104, 32'hA000_0108, 32'hA000_010C};
        do_write(4'h2, 32'h100, 2'b01, 8'd3, 4'hF);
        do_read(4'h2, 32'h100, 2'b01, 8'd3, 1);
        for (int k = 0; k < 4; k++)
            chk32($sformatf("incr_beat%0d", k), (rd_q.size() > k) ? rd_q[k] : 32'hxxxx_xxxx,
                  32'hA000_0100 + 32'(4 * k));

        // WRAP behaves as INCR
        do_read(4'h6, 32'h104, 2'b10, 8'd1, 2);
        chk32("wrap_beat1", (rd_q.size() > 1) ? rd_q[1] : 32'hxxxx_xxxx, 32'hA000_0108);

        // FIXED 3-beat write with awlen 0: wlast alone ends the burst
        wr_q = '{32'hDEAD_0024};
        do_write(4'h4, 32'h24, 2'b01, 8'd0, 4'hF);
        wr_q = '{32'd1, 32'd2, 32'd3};
        do_write(4'h4, 32'h20, 2'b00, 8'd0, 4'hF);
        do_read(4'h4, 32'h20, 2'b01, 8'd0, 0);
        chk32("fixed_write_last", (rd_q.size() > 0) ? rd_q[0] : 32'hxxxx_xxxx, 32'd3);
        do_read(4'h4, 32'h24, 2'b01, 8'd0, 0);
        chk32("fixed_neighbour", (rd_q.size() > 0) ? rd_q[0] : 32'hxxxx_xxxx, 32'hDEAD_0024);
        do_read(4'h4, 32'h20, 2'b00, 8'd2, 0);
        chk32("fixed_read_beat2", (rd_q.size() > 2) ? rd_q[2] : 32'hxxxx_xxxx, 32'd3);

        // W presented before AW is held off, then taken after the AW handshake
        wvalid = 1'b1; wdata = 32'h5555_AAAA; wstrb = 4'hF; wlast = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk1("w_held_before_aw", wready, 1'b0);
            tick();
        end
        wr_q = '{32'h5555_AAAA};
        do_write(4'h9, 32'h300, 2'b01, 8'd0, 4'hF);
        do_read(4'h9, 32'h1300, 2'b01, 8'd0, 0);
        chk32("early_w_alias", (rd_q.size() > 0) ? rd_q[0] : 32'hxxxx_xxxx, 32'h5555_AAAA);

        // Same-cycle write and read load of one word: read sees the old value
        wr_q = '{32'hAAAA_0001};
        do_write(4'h5, 32'h200, 2'b01, 8'd0, 4'hF);
        awid = 4'h5; awaddr = 32'h200; awburst = 2'b01; awlen = 8'd0; awvalid = 1'b1;
        cyc = 0;
        while (!awready && cyc < 200) begin tick(); cyc++; end
        chk1("col_aw_accept", awready, 1'b1);
        tick();
        awvalid = 1'b0;
        arid = 4'h5; araddr = 32'h200; arlen = 8'd0; arburst = 2'b01; arvalid = 1'b1;
        wvalid = 1'b1; wdata = 32'hBBBB_0002; wstrb = 4'hF; wlast = 1'b1;
        cyc = 0;
        while (!arready && cyc < 200) begin tick(); cyc++; end
        chk1("col_arready", arready, 1'b1);
        chk1("col_wready", wready, 1'b1);
        tick();
        arvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
        model_write(word_of(32'h200), 32'hBBBB_0002, 4'hF);
        rready = 1'b1;
        cyc = 0;
        while (!rvalid && cyc < 200) begin tick(); cyc++; end
        chk32("col_old_value", rdata, 32'hAAAA_0001);
        chk1("col_rlast", rlast, 1'b1);
        tick();
        rready = 1'b0;
        bready = 1'b1;
        cyc = 0;
        while (!bvalid && cyc < 200) begin tick(); cyc++; end
        chk1("col_bvalid", bvalid, 1'b1);
        tick();
        bready = 1'b0;
        do_read(4'h5, 32'h200, 2'b01, 8'd0, 0);
        chk32("col_new_value", (rd_q.size() > 0) ? rd_q[0] : 32'hxxxx_xxxx, 32'hBBBB_0002);

        // Reset during beat 2 of a 4-beat read
        arid = 4'h3; araddr = 32'h100; arlen = 8'd3; arburst = 2'b01; arvalid = 1'b1;
        cyc = 0;
        while (!arready && cyc < 200) begin tick(); cyc++; end
        tick();
        arvalid = 1'b0;
        rready = 1'b1;
        cyc = 0;
        while (!rvalid && cyc < 200) begin tick(); cyc++; end
        chk32("rst_mid_beat1", rdata, 32'hA000_0100);
        tick();
        rready = 1'b0;
        cyc = 0;
        while (!rvalid && cyc < 200) begin tick(); cyc++; end
        chk32("rst_mid_beat2", rdata, 32'hA000_0104);
        reset = 1'b1;
        tick();
        chk1("rst_mid_rvalid_drop", rvalid, 1'b0);
        chk1("rst_mid_no_b", bvalid, 1'b0);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
`ifndef AXI_SRAM_SLAVE_STALL_EN
            chk1("rst_mid_arready", arready, 1'b1);
`endif
            chk1("rst_mid_no_r", rvalid, 1'b0);
            rready = 1'b1;
            tick();
        end
        rready = 1'b0;
        cyc = 0;
        while (!arready && cyc < 200) begin tick(); cyc++; end
        chk1("rst_mid_arready_returns", arready, 1'b1);

        // Randomized bursts against the reference model
        wr_q.delete();
        for (int k = 0; k < 64; k++) wr_q.push_back($urandom());
        do_write(4'hC, 32'h0, 2'b01, 8'd63, 4'hF);
        for (int it = 0; it < 40; it++) begin
            logic [31:0] a;
            int          widx;
            logic [7:0]  ln;
            logic [1:0]  bu;
            widx = $urandom_range(0, 55);
            a  = ($urandom() & 32'hFFFF_F000) | (32'(widx) << 2) | 32'($urandom_range(0, 3));
            bu = 2'($urandom_range(0, 2));
            ln = 8'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                wr_q.delete();
                for (int k = 0; k <= int'(ln); k++) wr_q.push_back($urandom());
                do_write(4'($urandom_range(0, 15)), a, bu, ln, 4'($urandom_range(0, 15)));
            end else begin
                do_read(4'($urandom_range(0, 15)), a, bu, ln, int'($urandom_range(0, 2)));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL have parameter MEM_AW, default 10, giving the word-index width (memory = 2^MEM_AW x 32 bits).
REQ-002 SHALL have ports clk (input, 1) as the single clock and reset (input, 1) as the synchronous active-high reset.
REQ-003 SHALL have AR inputs arid[3:0], araddr[31:0], arlen[7:0], arburst[1:0], arvalid, and output arready, the read address channel.
REQ-004 SHALL have R outputs rid[3:0], rdata[31:0], rresp[1:0], rlast, rvalid, and input rready, the read data channel.
REQ-005 SHALL have AW inputs awid[3:0], awaddr[31:0], awlen[7:0], awburst[1:0], awvalid, and output awready, the write address channel.
REQ-006 SHALL have W inputs wdata[31:0], wstrb[3:0], wlast, wvalid, and output wready, the write data channel.
REQ-007 SHALL have B outputs bid[3:0], bresp[1:0], bvalid, and input bready, the write response channel.

Function
REQ-008 SHALL run read and write engines independently, each with at most one outstanding burst.
REQ-009 SHALL use read FSM states R_IDLE and R_BEAT: arready=1 only in R_IDLE; an AR handshake latches id, addr, len and burst, then moves to R_BEAT.
REQ-010 SHALL assert rvalid exactly one cycle after the AR handshake (first beat), with rdata = mem[addr[MEM_AW+1:2]] registered at launch.
REQ-011 SHALL, in R_BEAT, hold rvalid, rdata, rid and rlast stable until rready; each R handshake decrements the beat counter and loads the next beat's rdata in the same edge.
REQ-012 SHALL drive rlast=1 only on beat arlen+1; the R handshake with rlast returns the FSM to R_IDLE, with no bubble before the next AR accept.
REQ-013 SHALL advance the beat address by +4 for burst INCR (01) and WRAP (10, treated as INCR), and keep it constant for FIXED (00).
REQ-014 SHALL wrap the word index modulo 2^MEM_AW and ignore araddr/awaddr bits [1:0] and bits above MEM_AW+1.
REQ-015 SHALL use write FSM states W_IDLE, W_DATA and W_RESP: awready=1 only in W_IDLE; an AW handshake latches id, addr and burst, then moves to W_DATA.
REQ-016 SHALL assert wready=1 only in W_DATA; each W handshake writes wdata bytes enabled by wstrb into mem at the current address, then advances the address per REQ-013.
REQ-017 SHALL end the burst on the W handshake with wlast=1, regardless of awlen, and move to W_RESP.
REQ-018 SHALL, in W_RESP, assert bvalid with bid = latched awid, and return to W_IDLE on bready.
REQ-019 SHALL hold rresp = 2'b00 and bresp = 2'b00 at all times.
REQ-020 SHALL, when a W write and an R beat load hit the same word in the same cycle, give rdata the old (pre-write) value; the next load observes the new value.
REQ-021 SHALL ignore W beats presented before the AW handshake (wready=0) without loss.

Reset
REQ-022 SHALL, on reset, set both FSMs to IDLE; arready=awready=1 (after the first cycle), wready=rvalid=bvalid=rlast=0, rid=bid=0, rdata=0; memory contents are not reset.
REQ-023 SHALL, when reset is asserted mid-burst, abandon the burst next edge with no further R or B response.

Configuration
REQ-024 SHALL use macro AXI_SRAM_SLAVE_STALL_EN; when defined, a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 at reset, stepping every cycle) gates arready, awready, wready and first-beat/next-beat rvalid launch: each is allowed only when LFSR[0]=1, otherwise held off that cycle (rvalid, once asserted, is never dropped before handshake).
REQ-025 SHALL, when the macro is undefined, give exact no-stall timing per REQ-009 to REQ-018 and include no LFSR logic.

Verification
REQ-026 SHALL be verified by writing 32'h1234_5678 with wstrb 4'hF at 0x40 (awlen 0), then reading 0x40 -> rdata 32'h1234_5678, rlast=1, rresp 0, bid/rid echo 4'h1.
REQ-027 SHALL be verified by an INCR read with arlen 3 at 0x100, with rready toggling every cycle -> 4 beats at 0x100..0x10C, rdata stable while stalled, rlast only on beat 4.
REQ-028 SHALL be verified by wstrb 4'b0010 writing 32'hFFFF_FFFF over 32'h0 -> readback 32'h0000_FF00.
REQ-029 SHALL be verified by a FIXED write burst of 3 beats to 0x20 (values 1,2,3) -> readback 3, and a single bvalid only after the wlast beat.
REQ-030 SHALL be verified by address 0x1000 with MEM_AW=10 aliasing to 0x0, and by a same-cycle read/write collision returning the old value.
REQ-031 SHALL be verified by asserting reset during beat 2 of a 4-beat read -> rvalid=0 the next cycle and arready=1 thereafter; under STALL_EN, repeating REQ-026/027 gives identical data.
